// File: rtl/fp_compare_pipe.sv
// fp_compare_pipe: pipelined IEEE 754 SP/DP compare/min/max with valid/ready and sticky NV flag
module fp_compare_pipe #(
  parameter int PIPE_DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_dp,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic             out_lt,
  output logic             out_eq,
  output logic             out_gt,
  output logic             out_unord,
  output logic             out_invalid,
  output logic [TAG_W-1:0] out_tag,
  output logic             sticky_invalid,
  input  logic             flags_clr
);
  localparam int PW = 64 + 5 + TAG_W;
  logic en;
  logic [62:0] mag_a, mag_b;
  logic sa, sb, nan_a, nan_b, snan_a, snan_b, zero_a, zero_b, mag_lt, mag_eq;
  logic lt, eq, gt, unord, both_zero, a_lt_b_z, b_lt_a_z, bool_r, invalid;
  logic [63:0] mm_raw, mm_boxed, result;
  logic [PW-1:0] payload;
  logic [PW-1:0] stage_d [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] stage_v;
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  // Operand decode and relation; sign is stripped so denormals order by raw bits
  always_comb begin
    mag_a = in_dp ? in_a[62:0] : {32'b0, in_a[30:0]};
    mag_b = in_dp ? in_b[62:0] : {32'b0, in_b[30:0]};
    sa = in_dp ? in_a[63] : in_a[31];
    sb = in_dp ? in_b[63] : in_b[31];
    nan_a = (in_dp ? &in_a[62:52] : &in_a[30:23]) && (in_dp ? |in_a[51:0] : |in_a[22:0]);
    nan_b = (in_dp ? &in_b[62:52] : &in_b[30:23]) && (in_dp ? |in_b[51:0] : |in_b[22:0]);
    snan_a = nan_a && !(in_dp ? in_a[51] : in_a[22]);
    snan_b = nan_b && !(in_dp ? in_b[51] : in_b[22]);
    zero_a = ~|mag_a;
    zero_b = ~|mag_b;
    both_zero = zero_a && zero_b;
    mag_lt = mag_a < mag_b;
    mag_eq = mag_a == mag_b;
    unord = nan_a || nan_b;
    eq = !unord && (both_zero || (sa == sb && mag_eq));
    lt = !unord && !eq && ((sa != sb) ? sa : (sa ? !mag_lt : mag_lt));
    gt = !unord && !eq && !lt;
    a_lt_b_z = lt || (both_zero && sa && !sb);
    b_lt_a_z = gt || (both_zero && sb && !sa);
    bool_r = (in_op == 3'd0) ? eq : (in_op == 3'd1) ? lt : (lt || eq);
    invalid = (in_op == 3'd1 || in_op == 3'd2) ? unord : (in_op <= 3'd5) ? (snan_a || snan_b) : 1'b0;
  end
  // Min/max selection with NaN propagation, NaN-boxing for SP, and op mux
  always_comb begin
    mm_raw = (nan_a && nan_b) ? (in_dp ? 64'h7FF8000000000000 : 64'h000000007FC00000) :
             nan_a ? in_b : nan_b ? in_a :
             (in_op == 3'd4) ? (a_lt_b_z ? in_b : in_a) : (b_lt_a_z ? in_b : in_a);
    mm_boxed = in_dp ? mm_raw : {32'hFFFFFFFF, mm_raw[31:0]};
    result = (in_op == 3'd3 || in_op == 3'd4) ? mm_boxed : (in_op <= 3'd2) ? {63'b0, bool_r} : 64'b0;
    payload = {result, lt, eq, gt, unord, invalid, in_tag};
  end
  // Shift register of stages under the global enable; bubbles carry all-zero payloads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_v <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) stage_d[i] <= '0;
    end else if (en) begin
      stage_v[0] <= in_valid;
      stage_d[0] <= in_valid ? payload : '0;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        stage_v[i] <= stage_v[i-1];
        stage_d[i] <= stage_d[i-1];
      end
    end
  end
  assign out_valid = stage_v[PIPE_DEPTH-1];
  assign {out_result, out_lt, out_eq, out_gt, out_unord, out_invalid, out_tag} = stage_d[PIPE_DEPTH-1];
  // Sticky NV: a transfer of an invalid result wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_invalid <= 1'b0;
    else sticky_invalid <= (flags_clr ? 1'b0 : sticky_invalid) | (out_valid && out_ready && out_invalid);
  end
endmodule

// File: tb/tb_fp_compare_pipe.sv
// tb_fp_compare_pipe: directed scoreboard bench for fp_compare_pipe
module tb_fp_compare_pipe;
  localparam int D = 2;
  localparam logic [3:0] LT = 4'b1000, EQ = 4'b0100, GT = 4'b0010, UN = 4'b0001;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, in_dp = 0, out_valid, out_ready = 1;
  logic [2:0] in_op = 0;
  logic [63:0] in_a = 0, in_b = 0, out_result;
  logic [4:0] in_tag = 0, out_tag;
  logic out_lt, out_eq, out_gt, out_unord, out_invalid, sticky_invalid, flags_clr = 0;
  int checks = 0, fails = 0;
  typedef struct packed {
    logic [63:0] r;
    logic [3:0] rel;
    logic inv;
    logic [4:0] tag;
  } exp_t;
  exp_t q[$];

  fp_compare_pipe #(.PIPE_DEPTH(D), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_dp(in_dp), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_lt(out_lt), .out_eq(out_eq),
    .out_gt(out_gt), .out_unord(out_unord), .out_invalid(out_invalid), .out_tag(out_tag),
    .sticky_invalid(sticky_invalid), .flags_clr(flags_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic dp, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] tag, input logic [63:0] er, input logic [3:0] erel, input logic einv);
    int n = 0;
    in_op = op; in_dp = dp; in_a = a; in_b = b; in_tag = tag; in_valid = 1;
    #1;
    while (!in_ready && n < 50) begin step(); n++; end
    if (n == 50) chk("issue_timeout", 64'(in_ready), 64'd1);
    q.push_back('{r: er, rel: erel, inv: einv, tag: tag});
    step();
    in_valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && q.size() != 0; i++) step();
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  // Scoreboard: every transfer must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      assert (q.size() != 0) else begin
        fails++;
        $error("FAIL extra_result: observed tag %h with no pending expectation", out_tag);
      end
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("result", out_result, e.r);
        chk("relation", 64'({out_lt, out_eq, out_gt, out_unord}), 64'(e.rel));
        chk("invalid", 64'(out_invalid), 64'(e.inv));
        chk("tag", 64'(out_tag), 64'(e.tag));
      end
    end
  end

  initial begin
    int n;
    step(); step();
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_sticky", 64'(sticky_invalid), 0);
    rst_n = 1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 1);
    step();
    // Latency: SP FLT 1.0 < 2.0
    issue(3'd1, 0, 64'h3F800000, 64'h40000000, 5'd1, 64'd1, LT, 0);
    for (int i = 1; i < D; i++) begin chk("latency_early", 64'(out_valid), 0); step(); end
    chk("latency_valid", 64'(out_valid), 1);
    drain();
    // Signed zeros and other patterns
    issue(3'd0, 1, 64'h8000000000000000, 64'h0, 5'd2, 64'd1, EQ, 0);
    issue(3'd3, 1, 64'h8000000000000000, 64'h0, 5'd3, 64'h8000000000000000, EQ, 0);
    issue(3'd4, 1, 64'h8000000000000000, 64'h0, 5'd4, 64'h0, EQ, 0);
    issue(3'd2, 1, 64'hC000000000000000, 64'hBFF0000000000000, 5'd5, 64'd1, LT, 0);
    issue(3'd1, 0, 64'h00000001, 64'h00000002, 5'd6, 64'd1, LT, 0);
    issue(3'd2, 0, 64'h3F800000, 64'hBF800000, 5'd7, 64'd0, GT, 0);
    issue(3'd0, 0, 64'hDEADBEEF3F800000, 64'h3F800000, 5'd8, 64'd1, EQ, 0);
    issue(3'd3, 0, 64'h7FC00000, 64'h40000000, 5'd9, 64'hFFFFFFFF40000000, UN, 0);
    issue(3'd7, 0, 64'h7F800001, 64'h0, 5'd10, 64'd0, UN, 0);
    drain();
    chk("sticky_clean", 64'(sticky_invalid), 0);
    // NaN handling
    issue(3'd0, 0, 64'h7FC00000, 64'h3F800000, 5'd11, 64'd0, UN, 0);
    issue(3'd1, 0, 64'h7FC00000, 64'h3F800000, 5'd12, 64'd0, UN, 1);
    issue(3'd4, 0, 64'h7F800001, 64'h7FC00000, 5'd13, 64'hFFFFFFFF7FC00000, UN, 1);
    issue(3'd5, 0, 64'h7F800001, 64'h3F800000, 5'd14, 64'd0, UN, 1);
    drain();
    chk("sticky_set", 64'(sticky_invalid), 1);
    flags_clr = 1; step(); flags_clr = 0;
    chk("sticky_cleared", 64'(sticky_invalid), 0);
    // Clear coinciding with an invalid transfer keeps the flag
    issue(3'd1, 0, 64'h7FC00000, 64'h3F800000, 5'd15, 64'd0, UN, 1);
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    chk("sticky_wait_valid", 64'(out_valid), 1);
    flags_clr = 1; step();
    chk("sticky_clr_race", 64'(sticky_invalid), 1);
    step(); flags_clr = 0;
    chk("sticky_clr_alone", 64'(sticky_invalid), 0);
    // Backpressure
    issue(3'd1, 0, 64'h3F800000, 64'h40000000, 5'd16, 64'd1, LT, 0);
    issue(3'd1, 0, 64'h40000000, 64'h3F800000, 5'd17, 64'd0, GT, 0);
    issue(3'd0, 0, 64'h3F800000, 64'h3F800000, 5'd18, 64'd1, EQ, 0);
    out_ready = 0;
    in_op = 3'd2; in_dp = 0; in_a = 64'h40000000; in_b = 64'h40000000; in_tag = 5'd19; in_valid = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", 64'(in_ready), 0);
      chk("bp_out_valid", 64'(out_valid), 1);
      chk("bp_hold_tag", 64'(out_tag), 64'd17);
      chk("bp_hold_result", out_result, 64'd0);
      step();
    end
    out_ready = 1;
    issue(3'd2, 0, 64'h40000000, 64'h40000000, 5'd19, 64'd1, EQ, 0);
    drain();
    // Asynchronous reset with operations in flight
    issue(3'd1, 0, 64'h3F800000, 64'h40000000, 5'd20, 64'd1, LT, 0);
    issue(3'd1, 0, 64'h3F800000, 64'h40000000, 5'd21, 64'd1, LT, 0);
    rst_n = 0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 0);
    chk("arst_in_ready", 64'(in_ready), 1);
    q.delete();
    step(); step();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_no_stale", 64'(out_valid), 0);
      step();
    end
    chk("post_rst_in_ready", 64'(in_ready), 1);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
